// File: rtl/tree_acc_pkg.sv
// Shared types and constant helpers for the tree-sum accumulator.
// Holds the FSM encoding and the requantization constants.
package tree_acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FINALIZE,
    OUTPUT
  } acc_state_t;

  typedef struct packed {
    longint hi;
    longint lo;
  } sat_lim_t;

  // Signed range representable in w bits
  function automatic sat_lim_t sat_limits(int w);
    sat_lim_t l;
    l.hi = (longint'(1) << (w - 1)) - 1;
    l.lo = -(longint'(1) << (w - 1));
    return l;
  endfunction

  // Half-LSB offset that turns the shift into round-half-up
  function automatic longint round_const(int shift);
    return longint'(1) << (shift - 1);
  endfunction

endpackage

// File: rtl/requant_sat.sv
// Combinational requantizer: round, arithmetic shift,
// optional ReLU, then saturate to the output width.
module requant_sat
  import tree_acc_pkg::*;
#(
  parameter int ACC_WIDTH = 48,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_SHIFT = 8
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic                 relu_en,
  output logic [OUT_WIDTH-1:0] data,
  output logic                 sat
);

  // One guard bit so the rounding add cannot wrap
  localparam int RW = ACC_WIDTH + 1;
  localparam sat_lim_t LIM = sat_limits(OUT_WIDTH);
  localparam logic signed [RW-1:0] RND = RW'(round_const(OUT_SHIFT));
  localparam logic signed [RW-1:0] HI = RW'(LIM.hi);
  localparam logic signed [RW-1:0] LO = RW'(LIM.lo);

  logic signed [RW-1:0] biased;
  logic signed [RW-1:0] shifted;

  // Round, shift, then ReLU takes priority over saturation
  always_comb begin
    biased  = $signed({acc[ACC_WIDTH-1], acc}) + RND;
    shifted = biased >>> OUT_SHIFT;
    data    = shifted[OUT_WIDTH-1:0];
    sat     = 1'b0;
    if (relu_en && shifted[RW-1]) begin
      data = '0;
    end else if (shifted > HI) begin
      data = HI[OUT_WIDTH-1:0];
      sat  = 1'b1;
    end else if (shifted < LO) begin
      data = LO[OUT_WIDTH-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/tree_sum_accumulator.sv
// Accumulates several adder-tree sums per job and emits one
// requantized result on a valid/ready port.
module tree_sum_accumulator
  import tree_acc_pkg::*;
#(
  parameter int SUM_WIDTH      = 38,
  parameter int ACC_WIDTH      = 48,
  parameter int OUT_WIDTH      = 16,
  parameter int OUT_SHIFT      = 8,
  parameter int TREE_LATENCY   = 6,
  parameter int PASS_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      arst_in,
  input  logic                      start_in,
  input  logic [PASS_CNT_WIDTH-1:0] num_passes_in,
  input  logic                      relu_en_in,
  input  logic                      tree_valid_in,
  input  logic [SUM_WIDTH-1:0]      tree_sum_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_WIDTH-1:0]      out_data,
  output logic                      out_sat,
  output logic                      busy_out,
  output logic                      protocol_err_out
);

  if (ACC_WIDTH < SUM_WIDTH + PASS_CNT_WIDTH) begin : g_acc_chk
    $error("ACC_WIDTH too narrow for SUM_WIDTH+PASS_CNT_WIDTH");
  end
  if (OUT_SHIFT < 1) begin : g_shift_chk
    $error("OUT_SHIFT must be at least 1");
  end

  acc_state_t state;
  acc_state_t state_nx;

  logic [TREE_LATENCY-1:0]   vdl;
  logic                      sum_valid;
  logic [ACC_WIDTH-1:0]      acc;
  logic [ACC_WIDTH-1:0]      sum_ext;
  logic [PASS_CNT_WIDTH-1:0] pass_cnt;
  logic [PASS_CNT_WIDTH-1:0] pass_last;
  logic                      relu_en;
  logic                      take;
  logic                      cfg_load;
  logic [OUT_WIDTH-1:0]      rq_data;
  logic                      rq_sat;

  assign sum_valid = vdl[TREE_LATENCY-1];
  assign sum_ext   = {{(ACC_WIDTH-SUM_WIDTH){tree_sum_in[SUM_WIDTH-1]}},
                      tree_sum_in};
  assign cfg_load  = start_in && (state == IDLE || state == ACCUM);
  assign take      = sum_valid && state == ACCUM && !start_in;

  // Valid delay line matching the upstream tree pipeline
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      vdl <= '0;
    end else begin
      vdl[0] <= tree_valid_in;
      for (int i = 1; i < TREE_LATENCY; i++) vdl[i] <= vdl[i-1];
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) state <= IDLE;
    else         state <= state_nx;
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (start_in) state_nx = ACCUM;
      ACCUM: begin
        if (!start_in && take && pass_cnt == pass_last)
          state_nx = FINALIZE;
      end
      FINALIZE: state_nx = OUTPUT;
      OUTPUT:   if (out_ready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // FSM-decoded status outputs
  always_comb begin
    out_valid = (state == OUTPUT);
    busy_out  = (state != IDLE);
  end

  // Config latch, pass counter and accumulator
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      acc       <= '0;
      pass_cnt  <= '0;
      pass_last <= '0;
      relu_en   <= 1'b0;
    end else if (cfg_load) begin
      acc       <= '0;
      pass_cnt  <= '0;
      pass_last <= (num_passes_in == '0) ? '0
                 : num_passes_in - PASS_CNT_WIDTH'(1);
      relu_en   <= relu_en_in;
    end else if (take) begin
      acc      <= acc + sum_ext;
      pass_cnt <= pass_cnt + PASS_CNT_WIDTH'(1);
    end
  end

  requant_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_rq (
    .acc     (acc),
    .relu_en (relu_en),
    .data    (rq_data),
    .sat     (rq_sat)
  );

  // Result register, loaded once and held through backpressure
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (state == FINALIZE) begin
      out_data <= rq_data;
      out_sat  <= rq_sat;
    end
  end

  // Sticky flag for sums that arrive with no job accepting them
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in)                        protocol_err_out <= 1'b0;
    else if (sum_valid && state != ACCUM) protocol_err_out <= 1'b1;
  end

endmodule

// File: tb/tb_tree_sum_accumulator.sv
// Self-checking bench for tree_sum_accumulator.
// The bench plays the upstream tree and models results arithmetically.
module tb_tree_sum_accumulator;

  localparam int SW = 38;
  localparam int AW = 48;
  localparam int OW = 16;
  localparam int SH = 8;
  localparam int L  = 6;
  localparam int PW = 8;

  logic          clk = 0;
  logic          arst_in = 0;
  logic          start_in = 0;
  logic [PW-1:0] num_passes_in = '0;
  logic          relu_en_in = 0;
  logic          tree_valid_in = 0;
  logic [SW-1:0] tree_sum_in;
  logic          out_valid;
  logic          out_ready = 1;
  logic [OW-1:0] out_data;
  logic          out_sat;
  logic          busy_out;
  logic          protocol_err_out;

  logic [SW-1:0] op_sum = '0;
  logic [SW-1:0] sdl [L];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  bit            exp_err = 0;

  tree_sum_accumulator #(
    .SUM_WIDTH(SW), .ACC_WIDTH(AW), .OUT_WIDTH(OW),
    .OUT_SHIFT(SH), .TREE_LATENCY(L), .PASS_CNT_WIDTH(PW)
  ) dut (
    .clk(clk), .arst_in(arst_in), .start_in(start_in),
    .num_passes_in(num_passes_in), .relu_en_in(relu_en_in),
    .tree_valid_in(tree_valid_in), .tree_sum_in(tree_sum_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .busy_out(busy_out),
    .protocol_err_out(protocol_err_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the upstream tree: sum appears L cycles after its valid
  always @(posedge clk) begin
    sdl[0] <= op_sum;
    for (int i = 1; i < L; i++) sdl[i] <= sdl[i-1];
  end
  assign tree_sum_in = sdl[L-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_requant(input longint acc, input bit relu,
                                      output logic [OW-1:0] d,
                                      output bit sat);
    longint r;
    longint hi = (longint'(1) << (OW - 1)) - 1;
    longint lo = -(longint'(1) << (OW - 1));
    r = (acc + (longint'(1) << (SH - 1))) >>> SH;
    sat = 0;
    if (relu && r < 0) r = 0;
    else if (r > hi) begin r = hi; sat = 1; end
    else if (r < lo) begin r = lo; sat = 1; end
    d = OW'(r);
  endfunction

  // Full job: start, n back-to-back sums, check result, latency, handshake
  task automatic run_job(input string name, input int np, input bit relu,
                         input longint s[8], input int n);
    longint        acc = 0;
    int            t_last = 0;
    logic [OW-1:0] ed;
    bit            es;
    start_in = 1; num_passes_in = PW'(np); relu_en_in = relu;
    step();
    start_in = 0;
    for (int i = 0; i < n; i++) begin
      tree_valid_in = 1; op_sum = SW'(s[i]); acc += s[i];
      t_last = cyc;
      step();
    end
    tree_valid_in = 0;
    ref_requant(acc, relu, ed, es);
    for (int k = 0; k < 40 && !out_valid; k++) step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout out_valid got %b want 1", name, out_valid);
      return;
    end
    checks++;
    if (cyc !== t_last + L + 2) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", name, cyc - t_last, L + 2);
    end
    checks++;
    if (out_data !== ed) begin
      errors++;
      $display("FAIL %s out_data got %0d want %0d", name,
               $signed(out_data), $signed(ed));
    end
    checks++;
    if (out_sat !== es) begin
      errors++;
      $display("FAIL %s out_sat got %b want %b", name, out_sat, es);
    end
    checks++;
    if (protocol_err_out !== exp_err) begin
      errors++;
      $display("FAIL %s protocol_err got %b want %b", name,
               protocol_err_out, exp_err);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || busy_out !== 1'b0) begin
      errors++;
      $display("FAIL %s post_handshake valid/busy got %b%b want 00", name,
               out_valid, busy_out);
    end
  endtask

  task automatic check_idle_zero(input string name);
    checks++;
    if ({out_valid, out_data, out_sat, busy_out, protocol_err_out} !== '0) begin
      errors++;
      $display("FAIL %s reset_outputs got v=%b d=%0d s=%b b=%b e=%b want all 0",
               name, out_valid, $signed(out_data), out_sat, busy_out,
               protocol_err_out);
    end
  endtask

  task automatic test_reset();
    arst_in = 1;
    step(); step();
    check_idle_zero("reset");
    arst_in = 0;
    exp_err = 0;
    step();
    check_idle_zero("reset_release");
  endtask

  task automatic test_single_pass();
    longint s[8] = '{256, 0, 0, 0, 0, 0, 0, 0};
    run_job("single_pass", 1, 0, s, 1);
  endtask

  task automatic test_four_pass();
    longint s[8] = '{1000, -200, 300, 50, 0, 0, 0, 0};
    longint z[8] = '{777, 0, 0, 0, 0, 0, 0, 0};
    run_job("four_pass", 4, 0, s, 4);
    run_job("zero_passes", 0, 0, z, 1);
  endtask

  task automatic test_saturation();
    longint p[8] = '{longint'(1) << 30, 0, 0, 0, 0, 0, 0, 0};
    longint m[8] = '{-(longint'(1) << 30), 0, 0, 0, 0, 0, 0, 0};
    run_job("sat_pos", 1, 0, p, 1);
    run_job("sat_neg", 1, 0, m, 1);
    run_job("sat_neg_relu", 1, 1, m, 1);
  endtask

  task automatic test_relu_round();
    longint s[8] = '{-512, 0, 0, 0, 0, 0, 0, 0};
    longint h[8] = '{384, 0, 0, 0, 0, 0, 0, 0};
    run_job("round_neg", 1, 0, s, 1);
    run_job("relu_neg", 1, 1, s, 1);
    run_job("round_half", 1, 1, h, 1);
  endtask

  task automatic test_random();
    longint s[8];
    int     n, np;
    bit     relu;
    for (int j = 0; j < 10; j++) begin
      n = $urandom_range(1, 6);
      np = (n == 1 && $urandom_range(0, 1)) ? 0 : n;
      relu = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 1))
          s[i] = longint'($urandom_range(0, 200000)) - 100000;
        else
          s[i] = longint'(int'($urandom)) <<< $urandom_range(0, 5);
      end
      run_job($sformatf("random%0d", j), np, relu, s, n);
    end
  endtask

  task automatic test_backpressure();
    longint        s[8] = '{1000, 0, 0, 0, 0, 0, 0, 0};
    longint        f[8] = '{-300, 900, 0, 0, 0, 0, 0, 0};
    logic [OW-1:0] ed;
    bit            es;
    ref_requant(1000, 0, ed, es);
    out_ready = 0;
    start_in = 1; num_passes_in = 1; relu_en_in = 0;
    step();
    start_in = 0;
    tree_valid_in = 1; op_sum = SW'(s[0]);
    step();
    tree_valid_in = 0;
    for (int k = 0; k < 40 && !out_valid; k++) step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp timeout out_valid got %b want 1", out_valid);
    end
    tree_valid_in = 1; op_sum = SW'(12345);
    step();
    tree_valid_in = 0;
    for (int k = 0; k < L + 1; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== ed || out_sat !== es) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b d=%0d want v=1 d=%0d", k,
                 out_valid, $signed(out_data), $signed(ed));
      end
      step();
    end
    exp_err = 1;
    checks++;
    if (protocol_err_out !== 1'b1) begin
      errors++;
      $display("FAIL bp_err got %b want 1", protocol_err_out);
    end
    out_ready = 1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release out_valid got %b want 0", out_valid);
    end
    run_job("bp_follow", 2, 0, f, 2);
  endtask

  task automatic test_reset_mid();
    longint s[8] = '{-1000, 0, 0, 0, 0, 0, 0, 0};
    start_in = 1; num_passes_in = 4; relu_en_in = 0;
    step();
    start_in = 0;
    for (int i = 0; i < 4; i++) begin
      tree_valid_in = 1; op_sum = SW'(5000 + i);
      step();
    end
    tree_valid_in = 0;
    step(); step(); step(); step();
    arst_in = 1;
    #1;
    exp_err = 0;
    check_idle_zero("reset_mid");
    step();
    arst_in = 0;
    for (int k = 0; k < L + 2; k++) step();
    check_idle_zero("reset_mid_flush");
    run_job("after_reset", 1, 0, s, 1);
  endtask

  task automatic test_restart();
    longint s[8] = '{256, 0, 0, 0, 0, 0, 0, 0};
    start_in = 1; num_passes_in = 3; relu_en_in = 1;
    step();
    start_in = 0;
    tree_valid_in = 1; op_sum = SW'(50000);
    step();
    tree_valid_in = 0;
    for (int k = 0; k < L + 1; k++) step();
    checks++;
    if (busy_out !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL restart_partial busy/valid got %b%b want 10",
               busy_out, out_valid);
    end
    run_job("restart", 1, 0, s, 1);
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_four_pass();
    test_saturation();
    test_relu_round();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
